// File: rtl/line_adapter_pkg.sv
// Shared defaults and FSM state encoding for the cache-line to memory-burst adapter.
package line_adapter_pkg;

   localparam int DEF_CACHE_LINE_WIDTH = 256;
   localparam int DEF_BURST_LEN        = 4;
   localparam int DEF_BURST_WIDTH      = DEF_CACHE_LINE_WIDTH / DEF_BURST_LEN;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/line_burst_adapter.sv
// Converts one upstream cache-line fill/writeback into BURST_LEN memory beats.
//
// Memory handshake: while read_o or write_o is high, every cycle with resp_i=1
// transfers exactly one beat (burst_i captured on a read, burst_o consumed on a
// write); resp_i=0 is a wait cycle. Upstream holds read_i/write_i until the
// single-cycle resp_o pulse and drops it the following cycle.
module line_burst_adapter
   import line_adapter_pkg::*;
#(
   parameter int CACHE_LINE_WIDTH = DEF_CACHE_LINE_WIDTH,
   parameter int BURST_LEN        = DEF_BURST_LEN,
   parameter int ADDR_WIDTH       = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [ADDR_WIDTH-1:0]                 address_i,
   input  logic                                  read_i,
   input  logic                                  write_i,
   input  logic [CACHE_LINE_WIDTH-1:0]           line_i,
   output logic [CACHE_LINE_WIDTH-1:0]           line_o,
   output logic                                  resp_o,
   output logic [ADDR_WIDTH-1:0]                 address_o,
   output logic                                  read_o,
   output logic                                  write_o,
   input  logic [CACHE_LINE_WIDTH/BURST_LEN-1:0] burst_i,
   output logic [CACHE_LINE_WIDTH/BURST_LEN-1:0] burst_o,
   input  logic                                  resp_i,
   output state_t                                state_o
);

   localparam int BW  = CACHE_LINE_WIDTH / BURST_LEN;
   localparam int CW  = $clog2(BURST_LEN);
   localparam int OFS = $clog2(CACHE_LINE_WIDTH / 8);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

   state_t                      state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
   logic [CACHE_LINE_WIDTH-1:0] wline_q, wline_d;
   logic [CACHE_LINE_WIDTH-1:0] rline_q, rline_d;
   logic                        read_q, read_d;
   logic                        write_q, write_d;
   logic                        resp_q, resp_d;

   // Next-state and datapath: accept in IDLE, count beats, pulse resp in DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wline_d = wline_q;
      rline_d = rline_q;
      read_d  = read_q;
      write_d = write_q;
      resp_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (write_i || read_i) begin
               addr_d          = address_i;
               addr_d[OFS-1:0] = '0;
               wline_d         = line_i;
               cnt_d           = '0;
               if (write_i) begin
                  state_d = WRITE;
                  write_d = 1'b1;
               end else begin
                  state_d = READ;
                  read_d  = 1'b1;
               end
            end
         end
         READ: begin
            if (resp_i) begin
               rline_d[int'(cnt_q)*BW +: BW] = burst_i;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d = DONE;
                  read_d  = 1'b0;
                  resp_d  = 1'b1;
               end
            end
         end
         WRITE: begin
            if (resp_i) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d = DONE;
                  write_d = 1'b0;
                  resp_d  = 1'b1;
               end
            end
         end
         DONE: begin
            // Upstream still shows its request here; returning to IDLE without
            // looking at it keeps the same request from being taken twice.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            read_d  = 1'b0;
            write_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer and drops the partial line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wline_q <= '0;
         rline_q <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wline_q <= wline_d;
         rline_q <= rline_d;
         read_q  <= read_d;
         write_q <= write_d;
         resp_q  <= resp_d;
      end
   end

   // Write beat is selected straight from the latched line by the beat counter.
   always_comb begin
      burst_o = '0;
      if (write_q) begin
         burst_o = wline_q[int'(cnt_q)*BW +: BW];
      end
   end

   assign line_o    = rline_q;
   assign resp_o    = resp_q;
   assign address_o = addr_q;
   assign read_o    = read_q;
   assign write_o   = write_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: a table of line transactions plus
// hand-written reset-abort and stray-response sequences.
module tb_line_burst_adapter;
   import line_adapter_pkg::*;

   localparam int LW = 256;
   localparam int BL = 4;
   localparam int AW = 32;
   localparam int BW = LW / BL;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] address_i;
   logic          read_i;
   logic          write_i;
   logic [LW-1:0] line_i;
   logic [LW-1:0] line_o;
   logic          resp_o;
   logic [AW-1:0] address_o;
   logic          read_o;
   logic          write_o;
   logic [BW-1:0] burst_i;
   logic [BW-1:0] burst_o;
   logic          resp_i;
   state_t        state_o;

   int checks = 0;
   int errors = 0;
   logic [BW-1:0] exp_q[$];
   logic [LW-1:0] last_line;

   typedef struct {
      bit                     is_wr;
      bit                     both;
      logic [AW-1:0]          addr;
      logic [AW-1:0]          exp_addr;
      logic [LW-1:0]          line;   // read: expected line_o, write: line_i
      logic [BL-1:0][BW-1:0]  beats;  // read: memory beats, write: expected burst_o
      int                     waits;
      int                     gap;
   } vec_t;

   vec_t vecs[6];

   line_burst_adapter #(
      .CACHE_LINE_WIDTH(LW),
      .BURST_LEN(BL),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .address_i(address_i),
      .read_i(read_i),
      .write_i(write_i),
      .line_i(line_i),
      .line_o(line_o),
      .resp_o(resp_o),
      .address_o(address_o),
      .read_o(read_o),
      .write_o(write_o),
      .burst_i(burst_i),
      .burst_o(burst_o),
      .resp_i(resp_i),
      .state_o(state_o)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input bit is_wr, input bit both, input logic [AW-1:0] addr,
                               input logic [AW-1:0] exp_addr, input logic [LW-1:0] line,
                               input logic [LW-1:0] beats, input int waits, input int gap);
      vec_t v;
      v.is_wr    = is_wr;
      v.both     = both;
      v.addr     = addr;
      v.exp_addr = exp_addr;
      v.line     = line;
      v.beats    = beats;
      v.waits    = waits;
      v.gap      = gap;
      return v;
   endfunction

   // Driver: one full upstream transaction with the memory side answering.
   task automatic run_txn(input vec_t v);
      logic [BW-1:0] exp_beat;
      address_i = v.addr;
      line_i    = v.line;
      write_i   = v.is_wr;
      read_i    = !v.is_wr || v.both;
      resp_i    = 1'b0;
      tick();
      chk("accept_read_o", LW'(read_o), LW'(!v.is_wr));
      chk("accept_write_o", LW'(write_o), LW'(v.is_wr));
      chk("accept_addr", LW'(address_o), LW'(v.exp_addr));
      chk("accept_resp_o", LW'(resp_o), '0);
      // Inputs that must be ignored once the transfer is under way.
      address_i = ~v.addr;
      line_i    = ~v.line;
      if (v.is_wr) begin
         for (int k = 0; k < BL; k++) exp_q.push_back(v.beats[k]);
      end
      for (int w = 0; w < v.waits; w++) begin
         tick();
         chk("wait_addr", LW'(address_o), LW'(v.exp_addr));
         chk("wait_active", LW'(v.is_wr ? write_o : read_o), LW'(1));
         chk("wait_resp_o", LW'(resp_o), '0);
      end
      for (int k = 0; k < BL; k++) begin
         if (k == v.gap) begin
            resp_i = 1'b0;
            tick();
            chk("gap_addr", LW'(address_o), LW'(v.exp_addr));
            chk("gap_resp_o", LW'(resp_o), '0);
         end
         resp_i  = 1'b1;
         burst_i = v.is_wr ? BW'($urandom_range(0, 255)) : v.beats[k];
         chk("beat_active", LW'(v.is_wr ? write_o : read_o), LW'(1));
         chk("beat_other", LW'(v.is_wr ? read_o : write_o), '0);
         chk("beat_addr", LW'(address_o), LW'(v.exp_addr));
         if (v.is_wr) begin
            if (exp_q.size() == 0) begin
               chk("burst_o_queue", LW'(0), LW'(1));
            end else begin
               exp_beat = exp_q.pop_front();
               chk("burst_o", LW'(burst_o), LW'(exp_beat));
            end
         end
         tick();
      end
      resp_i = 1'b0;
      chk("done_resp_o", LW'(resp_o), LW'(1));
      chk("done_read_o", LW'(read_o), '0);
      chk("done_write_o", LW'(write_o), '0);
      chk("done_state", LW'(state_o), LW'(DONE));
      if (!v.is_wr) last_line = v.line;
      chk("done_line_o", line_o, last_line);
      read_i  = 1'b0;
      write_i = 1'b0;
      tick();
      chk("idle_resp_o", LW'(resp_o), '0);
      chk("idle_state", LW'(state_o), LW'(IDLE));
      chk("idle_line_o", line_o, last_line);
   endtask

   initial begin
      vecs[0] = mk(1'b0, 1'b0, 32'h0000_1234, 32'h0000_1220,
                   256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                   256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                   10, -1);
      vecs[1] = mk(1'b1, 1'b0, 32'h0000_0040, 32'h0000_0040,
                   256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF,
                   256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF,
                   0, -1);
      vecs[2] = mk(1'b0, 1'b0, 32'h8000_003F, 32'h8000_0020,
                   256'h3132333435363738_2122232425262728_1112131415161718_0102030405060708,
                   256'h3132333435363738_2122232425262728_1112131415161718_0102030405060708,
                   0, 2);
      vecs[3] = mk(1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEE0,
                   256'hD3D3D3D3D3D3D3D3_C2C2C2C2C2C2C2C2_B1B1B1B1B1B1B1B1_A0A0A0A0A0A0A0A0,
                   256'hD3D3D3D3D3D3D3D3_C2C2C2C2C2C2C2C2_B1B1B1B1B1B1B1B1_A0A0A0A0A0A0A0A0,
                   1, -1);
      vecs[4] = mk(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
                   256'h00000000000000FF_000000000000FF00_0000000000FF0000_00000000FF000000,
                   256'h00000000000000FF_000000000000FF00_0000000000FF0000_00000000FF000000,
                   2, 1);
      vecs[5] = mk(1'b0, 1'b0, 32'h0000_0100, 32'h0000_0100,
                   256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555,
                   256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555,
                   0, 3);

      // Reset
      rst       = 1'b1;
      address_i = '0;
      read_i    = 1'b0;
      write_i   = 1'b0;
      line_i    = '0;
      burst_i   = '0;
      resp_i    = 1'b0;
      last_line = '0;
      tick();
      tick();
      chk("rst_read_o", LW'(read_o), '0);
      chk("rst_write_o", LW'(write_o), '0);
      chk("rst_resp_o", LW'(resp_o), '0);
      chk("rst_address_o", LW'(address_o), '0);
      chk("rst_line_o", line_o, '0);
      chk("rst_burst_o", LW'(burst_o), '0);
      chk("rst_state", LW'(state_o), LW'(IDLE));
      rst = 1'b0;
      tick();

      // Read, back-to-back write then read.
      for (int i = 0; i < 3; i++) run_txn(vecs[i]);

      // Stray resp_i while idle must not move the FSM or touch line_o.
      resp_i  = 1'b1;
      burst_i = 64'hBAD0BAD0BAD0BAD0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stray_state", LW'(state_o), LW'(IDLE));
         chk("stray_read_o", LW'(read_o | write_o), '0);
         chk("stray_resp_o", LW'(resp_o), '0);
         chk("stray_line_o", line_o, last_line);
      end
      resp_i = 1'b0;
      tick();

      // Simultaneous request, then a write with waits and a gap.
      run_txn(vecs[3]);
      run_txn(vecs[4]);

      // Reset after two read beats aborts the fill.
      address_i = 32'h0000_0100;
      read_i    = 1'b1;
      tick();
      resp_i  = 1'b1;
      burst_i = 64'hDEADDEADDEADDEAD;
      tick();
      burst_i = 64'hBEEFBEEFBEEFBEEF;
      tick();
      rst    = 1'b1;
      resp_i = 1'b0;
      tick();
      chk("abort_read_o", LW'(read_o), '0);
      chk("abort_resp_o", LW'(resp_o), '0);
      chk("abort_state", LW'(state_o), LW'(IDLE));
      chk("abort_line_o", line_o, '0);
      chk("abort_address_o", LW'(address_o), '0);
      rst    = 1'b0;
      read_i = 1'b0;
      last_line = '0;
      tick();
      chk("abort_after_resp_o", LW'(resp_o), '0);
      chk("abort_after_read_o", LW'(read_o), '0);
      run_txn(vecs[5]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
